sha_rot_xor_pipe: RTL and testbench
===================================

Name: sha_rot_xor_pipe

Overview:
Parametrised, pipelined rotate/shift-XOR unit for the SHA-2 message schedule and compression rounds. It replaces the fixed-wire rotate blocks with a single unit. The unit supports a runtime rotate amount and the four SHA-2 sigma functions, at 32-bit (SHA-256) or 64-bit (SHA-512) word width. It sits between the schedule/round controllers and the adder trees, behind a valid/ready handshake with full-throughput backpressure.

Parameters:
W, 32, word width; only 32 or 64 are legal, any other value is an elaboration error.
AW, $clog2(W), rotate-amount width; derived, not overridden.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input operand valid
in_ready  out  1  unit can accept an operand this cycle
in_mode  in  3  0=ROTR(in_amt), 1=sigma0, 2=sigma1, 3=Sigma0, 4=Sigma1, 5..7 illegal
in_amt  in  AW  rotate amount; used in mode 0 only
in_data  in  W  operand
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  W  result
out_err  out  1  result came from an illegal mode; qualified by out_valid
perf_cnt  out  32  completed-transfer count (see Optional Feature)

Behaviour:
- One clock, clk; reset rst is synchronous and active-high. During and after reset: out_valid=0, out_data=0, out_err=0, perf_cnt=0, both stage valids cleared. in_ready=1 in the first cycle after rst deasserts.
- Pipeline has two register stages.
  - S1 captures mode, amt and data on input accept (in_valid & in_ready).
  - S2 holds the computed result and drives the out_* ports.
  - Latency: accept at cycle N gives out_valid at N+2 when there is no stall.
- Stall logic:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv, purely combinational from state and out_ready. No input-to-output combinational path other than this ready chain.
- Throughput is one result per cycle while out_ready=1.
- While out_ready=0 with out_valid=1, out_data and out_err hold stable. Both stages fill, then in_ready drops. No data is lost or duplicated.
- Simultaneous accept and emit in the same cycle is legal at every stage.
- Arithmetic: ROTR(x,n) = (x>>n)|(x<<(W-n)), with n=0 giving identity. SHR is a logical shift with zero fill.
- W=32 constants:
  - sigma0 = R7^R18^S3
  - sigma1 = R17^R19^S10
  - Sigma0 = R2^R13^R22
  - Sigma1 = R6^R11^R25
- W=64 constants:
  - sigma0 = R1^R8^S7
  - sigma1 = R19^R61^S6
  - Sigma0 = R28^R34^R39
  - Sigma1 = R14^R18^R41
- Illegal mode (5..7): result is 0 and out_err=1. The transfer is otherwise normal and does not stall.
- Reset mid-operation: all in-flight results are discarded. No output fires in the cycle after reset.

Optional Feature:
Macro SHA_ROT_PERF_CNT_EN.
- Defined: perf_cnt increments on every out_valid & out_ready. It is 32 bits and wraps from 0xFFFFFFFF to 0. rst clears it.
- Undefined: perf_cnt is tied to 0 and no counter flops are generated.

Decomposition:
- Shared package sha_rot_pkg holds:
  - mode enum: MODE_ROTR, MODE_SSIG0, MODE_SSIG1, MODE_BSIG0, MODE_BSIG1.
  - rotate/shift constant sets for W=32 and W=64.
  - helper function rotr(x,n).
- One sub-module, sha_rot_xor_core: purely combinational mode/data/amt -> result/err, instantiated between S1 and S2. The wrapper owns the handshake and registers.

Test Plan:
1. W=32, mode 0, amt=18, data 0x00000001, out_ready=1 -> out_data 0x00004000 two cycles later; amt=0, data 0xDEADBEEF -> 0xDEADBEEF.
2. W=32, data 0x00000001 streamed back-to-back through modes 1,2,3,4, out_ready=1 -> results 0x02004000, 0x0000A000, 0x40080400, 0x04200080 on four consecutive cycles.
3. Backpressure: stream 5 operands with out_ready=0 for 6 cycles -> in_ready low after 2 accepts, out_data held, all 5 results delivered in order once out_ready=1.
4. Mode 6, data 0xFFFFFFFF -> out_data 0, out_err=1; next operand in mode 0 -> out_err=0.
5. rst asserted for one cycle while 2 results are in flight -> out_valid=0 the next cycle, nothing emitted, in_ready=1.
6. With SHA_ROT_PERF_CNT_EN and W=64: 10 transfers -> perf_cnt=10; mode 0, amt=63, data 0x1 -> 0x0000000000000002.

Source files
------------

// File: rtl/sha_rot_pkg.sv
// Shared definitions for the SHA-2 rotate/shift-XOR unit: mode encoding,
// sigma rotate/shift constant sets and the rotate helper.
package sha_rot_pkg;

  typedef enum logic [2:0] {
    MODE_ROTR  = 3'd0,
    MODE_SSIG0 = 3'd1,
    MODE_SSIG1 = 3'd2,
    MODE_BSIG0 = 3'd3,
    MODE_BSIG1 = 3'd4
  } mode_e;

  // Rows: sigma0, sigma1, Sigma0, Sigma1. Columns 0/1 are rotates; column 2 is
  // a logical shift for the small sigmas and a third rotate for the big ones.
  localparam int ROT32 [4][3] = '{'{7, 18, 3}, '{17, 19, 10}, '{2, 13, 22}, '{6, 11, 25}};
  localparam int ROT64 [4][3] = '{'{1, 8, 7}, '{19, 61, 6}, '{28, 34, 39}, '{14, 18, 41}};

  function automatic logic [6:0] kc(input logic [1:0] f, input logic [1:0] t, input bit wide);
    return wide ? 7'(ROT64[f][t]) : 7'(ROT32[f][t]);
  endfunction

  // Operand lives in the low w bits of x with zero upper bits; n=0 yields x
  // because the left shift by w lands entirely outside the mask.
  function automatic logic [63:0] rotr(input logic [63:0] x, input logic [6:0] n,
                                       input int unsigned w);
    logic [63:0] mask;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((x >> n) | (x << (7'(w) - n))) & mask;
  endfunction

endpackage

// File: rtl/sha_rot_xor_core.sv
// Combinational ROTR / SHA-2 sigma datapath; illegal modes return 0 with err.
module sha_rot_xor_core
  import sha_rot_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]         mode,
  input  logic [$clog2(W)-1:0] amt,
  input  logic [W-1:0]       data,
  output logic [W-1:0]       result,
  output logic               err
);

  localparam bit WIDE = (W == 64);

  logic [63:0] x, r;

  function automatic logic [63:0] sig(input logic [63:0] v, input logic [1:0] f, input bit big);
    logic [63:0] t2;
    t2 = big ? rotr(v, kc(f, 2'd2, WIDE), W) : (v >> kc(f, 2'd2, WIDE));
    return rotr(v, kc(f, 2'd0, WIDE), W) ^ rotr(v, kc(f, 2'd1, WIDE), W) ^ t2;
  endfunction

  always_comb begin
    x   = 64'(data);
    r   = '0;
    err = 1'b0;
    case (mode)
      MODE_ROTR:  r = rotr(x, 7'(amt), W);
      MODE_SSIG0: r = sig(x, 2'd0, 1'b0);
      MODE_SSIG1: r = sig(x, 2'd1, 1'b0);
      MODE_BSIG0: r = sig(x, 2'd2, 1'b1);
      MODE_BSIG1: r = sig(x, 2'd3, 1'b1);
      default:    err = 1'b1;
    endcase
  end

  assign result = r[W-1:0];

endmodule

// File: rtl/sha_rot_xor_pipe.sv
// Two-stage valid/ready rotate/sigma pipeline around sha_rot_xor_core.
// Optional completed-transfer counter: define SHA_ROT_PERF_CNT_EN.
module sha_rot_xor_pipe
  import sha_rot_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_mode,
  input  logic [$clog2(W)-1:0] in_amt,
  input  logic [W-1:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic                 out_err,
  output logic [31:0]          perf_cnt
);

  localparam int AW = $clog2(W);

  if (W != 32 && W != 64) begin : g_bad_w
    $error("sha_rot_xor_pipe: W must be 32 or 64");
  end

  logic          s1_valid, s2_valid, s1_adv, s2_adv;
  logic [2:0]    s1_mode;
  logic [AW-1:0] s1_amt;
  logic [W-1:0]  s1_data, s2_data, core_res;
  logic          s2_err, core_err;

  // Each stage may load while the one ahead drains in the same cycle.
  assign s2_adv   = !s2_valid | out_ready;
  assign s1_adv   = !s1_valid | s2_adv;
  assign in_ready = s1_adv;

  sha_rot_xor_core #(.W(W)) u_core (
    .mode   (s1_mode),
    .amt    (s1_amt),
    .data   (s1_data),
    .result (core_res),
    .err    (core_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_amt   <= '0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_err   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_mode <= in_mode;
          s1_amt  <= in_amt;
          s1_data <= in_data;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= core_res;
          s2_err  <= core_err;
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_err   = s2_err;

`ifdef SHA_ROT_PERF_CNT_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk) begin
    if (rst)                         perf_q <= '0;
    else if (s2_valid && out_ready)  perf_q <= perf_q + 32'd1;
  end
  assign perf_cnt = perf_q;
`else
  assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_sha_rot_xor_pipe.sv
// Self-checking bench for sha_rot_xor_pipe at W=32 and W=64 against a
// bit-level rotate reference model and a result scoreboard.
module tb_sha_rot_xor_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]  in_mode;
  logic [4:0]  in_amt;
  logic [31:0] in_data, out_data, perf_cnt;

  logic        v64, r64, ov64, ordy64, oe64;
  logic [2:0]  m64;
  logic [5:0]  a64;
  logic [63:0] d64, od64;
  logic [31:0] pc64;

  int passed = 0;
  int total  = 0;
  int xfers  = 0;
  logic [32:0] expq[$];

  sha_rot_xor_pipe #(.W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_amt(in_amt), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .perf_cnt(perf_cnt)
  );

  sha_rot_xor_pipe #(.W(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(r64), .in_mode(m64),
    .in_amt(a64), .in_data(d64), .out_valid(ov64), .out_ready(ordy64),
    .out_data(od64), .out_err(oe64), .perf_cnt(pc64)
  );

  // Reference: rotation defined bit by bit, sigma constants straight from SHA-2.
  function automatic logic [63:0] m_rot(input logic [63:0] x, input int n, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = x[(i + n) % w];
    return r;
  endfunction

  function automatic logic [64:0] model(input int mode, input int amt, input logic [63:0] x,
                                        input int w);
    int k[4][3];
    if (w == 32) k = '{'{7, 18, 3}, '{17, 19, 10}, '{2, 13, 22}, '{6, 11, 25}};
    else         k = '{'{1, 8, 7}, '{19, 61, 6}, '{28, 34, 39}, '{14, 18, 41}};
    case (mode)
      0:       return {1'b0, m_rot(x, amt, w)};
      1, 2:    return {1'b0, m_rot(x, k[mode-1][0], w) ^ m_rot(x, k[mode-1][1], w) ^ (x >> k[mode-1][2])};
      3, 4:    return {1'b0, m_rot(x, k[mode-1][0], w) ^ m_rot(x, k[mode-1][1], w) ^ m_rot(x, k[mode-1][2], w)};
      default: return {1'b1, 64'd0};
    endcase
  endfunction

  // One cycle on the W=32 unit: drive at negedge, sample handshakes, advance.
  task automatic step(input logic v, input logic [2:0] m, input logic [4:0] a,
                      input logic [31:0] d, input logic ordy,
                      output logic acc, output logic emit, output logic [31:0] od,
                      output logic oe);
    logic [64:0] r;
    in_valid = v; in_mode = m; in_amt = a; in_data = d; out_ready = ordy;
    #1;
    acc  = v & in_ready;
    emit = out_valid & ordy;
    od   = out_data;
    oe   = out_err;
    if (acc) begin
      r = model(int'(m), int'(a), 64'(d), 32);
      expq.push_back({r[64], r[31:0]});
    end
    if (emit) xfers++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; v64 = 1'b0; ordy64 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expq.delete();
    xfers = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 32'd0) $display("FAIL reset_out_data got %h want 0", out_data); else passed++;
    total++; if (out_err !== 1'b0) $display("FAIL reset_out_err got %b want 0", out_err); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    total++; if (perf_cnt !== 32'd0) $display("FAIL reset_perf_cnt got %h want 0", perf_cnt); else passed++;
    @(negedge clk);
  endtask

  task automatic test_rotr();
    logic acc, emit, oe; logic [31:0] od; logic [32:0] e;
    logic [31:0] want [2] = '{32'h0000_4000, 32'hDEAD_BEEF};
    step(1, 3'd0, 5'd18, 32'h1, 1, acc, emit, od, oe);
    step(1, 3'd0, 5'd0, 32'hDEAD_BEEF, 1, acc, emit, od, oe);
    total++; if (emit !== 1'b0) $display("FAIL rotr_latency early out_valid got %b want 0", emit); else passed++;
    for (int i = 0; i < 2; i++) begin
      step(0, 3'd0, 5'd0, 32'h0, 1, acc, emit, od, oe);
      e = expq.size() ? expq.pop_front() : 33'h1_FFFF_FFFF;
      total++;
      if (emit !== 1'b1 || od !== want[i] || oe !== 1'b0 || e !== {1'b0, want[i]})
        $display("FAIL rotr_%0d got v=%b d=%h e=%b want v=1 d=%h e=0 model=%h", i, emit, od, oe, want[i], e);
      else passed++;
    end
  endtask

  task automatic test_sigmas();
    logic acc, emit, oe; logic [31:0] od; logic [32:0] e;
    logic [31:0] want [4] = '{32'h0200_4000, 32'h0000_A000, 32'h4008_0400, 32'h0420_0080};
    for (int i = 0; i < 6; i++) begin
      step(i < 4, 3'(i + 1), 5'd0, 32'h1, 1, acc, emit, od, oe);
      if (i >= 2) begin
        e = expq.size() ? expq.pop_front() : 33'h1_FFFF_FFFF;
        total++;
        if (emit !== 1'b1 || od !== want[i-2] || oe !== 1'b0 || e !== {1'b0, want[i-2]})
          $display("FAIL sigma_mode%0d got v=%b d=%h want d=%h model=%h", i - 1, emit, od, want[i-2], e);
        else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic acc, emit, oe; logic [31:0] od, held; logic [32:0] e;
    logic [31:0] ops [5];
    int nacc = 0, nemit = 0, cyc = 0;
    for (int i = 0; i < 5; i++) ops[i] = $urandom;
    for (int i = 0; i < 6; i++) begin
      step(1, 3'(i % 5), 5'(i * 7), ops[nacc], 0, acc, emit, od, oe);
      if (acc) nacc++;
      if (i == 2) held = od;
      if (i > 2) begin
        total++; if (od !== held) $display("FAIL bp_hold cyc%0d got %h want %h", i, od, held); else passed++;
      end
    end
    total++; if (nacc !== 2) $display("FAIL bp_accepts got %0d want 2", nacc); else passed++;
    while ((nemit < 5) && (cyc < 30)) begin
      step(nacc < 5, 3'(nacc % 5), 5'(nacc * 7), nacc < 5 ? ops[nacc] : 32'h0, 1, acc, emit, od, oe);
      if (acc) nacc++;
      if (emit) begin
        nemit++;
        e = expq.size() ? expq.pop_front() : 33'h1_FFFF_FFFF;
        total++; if ({oe, od} !== e) $display("FAIL bp_data got %h want %h", {oe, od}, e); else passed++;
      end
      cyc++;
    end
    total++; if (nemit !== 5) $display("FAIL bp_delivered got %0d want 5", nemit); else passed++;
  endtask

  task automatic test_illegal();
    logic acc, emit, oe; logic [31:0] od; logic [32:0] e;
    step(1, 3'd6, 5'd0, 32'hFFFF_FFFF, 1, acc, emit, od, oe);
    step(1, 3'd0, 5'd4, 32'h1234_5678, 1, acc, emit, od, oe);
    step(0, 3'd0, 5'd0, 32'h0, 1, acc, emit, od, oe);
    e = expq.size() ? expq.pop_front() : 33'h0;
    total++;
    if (emit !== 1'b1 || od !== 32'h0 || oe !== 1'b1 || e !== {1'b1, 32'h0})
      $display("FAIL illegal_mode got v=%b d=%h e=%b want v=1 d=0 e=1", emit, od, oe);
    else passed++;
    step(0, 3'd0, 5'd0, 32'h0, 1, acc, emit, od, oe);
    e = expq.size() ? expq.pop_front() : 33'h1_FFFF_FFFF;
    total++;
    if (emit !== 1'b1 || oe !== 1'b0 || {oe, od} !== e || od !== 32'h8123_4567)
      $display("FAIL after_illegal got v=%b d=%h e=%b want d=81234567 e=0", emit, od, oe);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic acc, emit, oe; logic [31:0] od;
    int stray = 0;
    step(1, 3'd1, 5'd0, 32'hA5A5_A5A5, 1, acc, emit, od, oe);
    step(1, 3'd2, 5'd0, 32'h5A5A_5A5A, 0, acc, emit, od, oe);
    do_reset();
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %b want 1", in_ready); else passed++;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step(0, 3'd0, 5'd0, 32'h0, 1, acc, emit, od, oe);
      if (emit) stray++;
    end
    total++; if (stray !== 0) $display("FAIL rstmid_stray got %0d want 0", stray); else passed++;
  endtask

  task automatic test_random();
    logic acc, emit, oe; logic [31:0] od; logic [32:0] e;
    int bad = 0, n = 0;
    for (int i = 0; i < 400 || (expq.size() != 0 && i < 420); i++) begin
      step(i < 400 && ($urandom_range(3) != 0), 3'($urandom_range(7)), 5'($urandom),
           $urandom, (i >= 400) || ($urandom_range(3) != 0), acc, emit, od, oe);
      if (emit) begin
        n++;
        e = expq.size() ? expq.pop_front() : 33'h1_FFFF_FFFF;
        if ({oe, od} !== e) begin
          bad++;
          if (bad < 5) $display("FAIL random_data got %h want %h", {oe, od}, e);
        end
      end
    end
    total++; if (bad !== 0 || n == 0) $display("FAIL random_stream bad=%0d results=%0d want 0 bad", bad, n); else passed++;
    total++; if (expq.size() !== 0) $display("FAIL random_drain left %0d want 0", expq.size()); else passed++;
  endtask

  task automatic test_perf();
    logic acc, emit, oe; logic [31:0] od, want;
    do_reset();
    for (int i = 0; i < 12; i++) step(i < 10, 3'd0, 5'd1, 32'h0, 1, acc, emit, od, oe);
`ifdef SHA_ROT_PERF_CNT_EN
    want = 32'(xfers);
`else
    want = 32'd0;
`endif
    total++; if (perf_cnt !== want || xfers !== 10) $display("FAIL perf_cnt got %0d want %0d (xfers %0d)", perf_cnt, want, xfers); else passed++;
    expq.delete();
  endtask

  task automatic test_w64();
    logic [64:0] r; logic [64:0] eq[$]; logic [64:0] e;
    int bad = 0, n = 0, acc = 0;
    logic [31:0] want;
    for (int i = 0; i < 30; i++) begin
      v64 = (i < 20); ordy64 = 1'b1;
      m64 = (i == 0) ? 3'd0 : 3'($urandom_range(7));
      a64 = (i == 0) ? 6'd63 : 6'($urandom);
      d64 = (i == 0) ? 64'h1 : {$urandom, $urandom};
      #1;
      if (ov64) begin
        e = eq.size() ? eq.pop_front() : {1'b1, 64'hDEAD};
        if (n == 0) begin
          total++;
          if (od64 !== 64'h2 || oe64 !== 1'b0) $display("FAIL w64_rotr63 got %h want 0000000000000002", od64); else passed++;
        end
        if ({oe64, od64} !== e) begin
          bad++;
          if (bad < 5) $display("FAIL w64_data got %h want %h", {oe64, od64}, e);
        end
        n++;
      end
      if (v64 && r64) begin
        acc++;
        r = model(int'(m64), int'(a64), d64, 64);
        eq.push_back(r);
      end
      @(posedge clk);
      @(negedge clk);
    end
    v64 = 1'b0;
    total++; if (bad !== 0 || n !== 20) $display("FAIL w64_stream bad=%0d results=%0d want 0/20", bad, n); else passed++;
`ifdef SHA_ROT_PERF_CNT_EN
    want = 32'(n);
`else
    want = 32'd0;
`endif
    total++; if (pc64 !== want) $display("FAIL w64_perf got %0d want %0d", pc64, want); else passed++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mode = '0; in_amt = '0; in_data = '0; out_ready = 1'b1;
    v64 = 1'b0; m64 = '0; a64 = '0; d64 = '0; ordy64 = 1'b1;
    @(negedge clk);
    test_reset();
    test_rotr();
    test_sigmas();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
    test_perf();
    do_reset();
    test_w64();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
